// File: rtl/noc_pkg.sv
// Shared mesh definitions: coordinates, flit type encodings, router port codes
// and the packetizer FSM states.
package noc_pkg;

    localparam int X_NODE_NUM = 4;
    localparam int Y_NODE_NUM = 4;
    localparam int X_W        = 2;
    localparam int Y_W        = 2;
    localparam int FLIT_W     = 8;
    localparam int LEN_W      = 4;

    localparam logic [1:0] HDR_FLIT  = 2'b10;
    localparam logic [1:0] BODY_FLIT = 2'b00;
    localparam logic [1:0] TAIL_FLIT = 2'b01;

    localparam logic [2:0] Lo = 3'd1;
    localparam logic [2:0] Eo = 3'd2;
    localparam logic [2:0] No = 3'd3;
    localparam logic [2:0] Wo = 3'd4;
    localparam logic [2:0] So = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        PAYLOAD
    } ni_state_t;

    // Header layout decoded by the router's route-compute stage
    function automatic logic [FLIT_W-1:0] make_header(
        input logic [X_W-1:0] src_x,
        input logic [Y_W-1:0] src_y,
        input logic [X_W-1:0] dst_x,
        input logic [Y_W-1:0] dst_y
    );
        return {src_x, src_y, dst_x, dst_y};
    endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// Core-side request/payload handshakes and router-side flit/credit signals.
interface ni_packetizer_if;
    import noc_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [X_W-1:0]      req_dest_x;
    logic [Y_W-1:0]      req_dest_y;
    logic [LEN_W-1:0]    req_len;
    logic                data_valid;
    logic                data_ready;
    logic [FLIT_W-1:0]   data_in;
    logic                flit_valid;
    logic [FLIT_W-1:0]   flit_out;
    logic [1:0]          flit_type;
    logic                credit_in;
    logic                credit_err;

    modport master (
        input  req_valid, req_dest_x, req_dest_y, req_len,
        input  data_valid, data_in, credit_in,
        output req_ready, data_ready, flit_valid, flit_out, flit_type, credit_err
    );

    modport slave (
        output req_valid, req_dest_x, req_dest_y, req_len,
        output data_valid, data_in, credit_in,
        input  req_ready, data_ready, flit_valid, flit_out, flit_type, credit_err
    );

endinterface

// File: rtl/ni_packetizer_credit_counter.sv
// Saturating credit counter for the router local input buffer, with a sticky
// error for credits returned while already full.
module credit_counter #(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic credit_in,
    output logic has_credit,
    output logic credit_err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // A send and a returned credit in the same cycle cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= FULL;
            credit_err <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10: count <= count - ONE;
                2'b01: begin
                    if (count == FULL) credit_err <= 1'b1;
                    else               count      <= count + ONE;
                end
                default: ;
            endcase
        end
    end

    assign has_credit = (count != '0);

endmodule

// File: rtl/ni_packetizer.sv
// Source-side network interface: turns a packet request plus payload words into
// header/body/tail flits for the router local port under credit flow control.
module ni_packetizer
    import noc_pkg::*;
#(
    parameter logic [X_W-1:0] X_S_ADDRESS = 2'b00,
    parameter logic [Y_W-1:0] Y_S_ADDRESS = 2'b01,
    parameter int             BUF_DEPTH   = 4,
    parameter int             CNT_W       = 3
) (
    input logic             clk,
    input logic             rst,
    ni_packetizer_if.master bus
);

    ni_state_t         state, state_next;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;
    logic [LEN_W-1:0]  remain;
    logic              has_credit;
    logic              hdr_send;
    logic              data_fire;
    logic              send;
    logic              req_ready;
    logic              data_ready;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        flit_type;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        hdr_send   = 1'b0;
        data_fire  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_next = HEAD;
            end
            HEAD: begin
                hdr_send = has_credit;
                if (has_credit) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                data_ready = has_credit;
                data_fire  = has_credit && bus.data_valid;
                if (data_fire && remain == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        send = hdr_send || data_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // flit_out/flit_type only change when a flit is actually emitted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_x     <= '0;
            dest_y     <= '0;
            remain     <= '0;
            flit_valid <= 1'b0;
            flit_out   <= '0;
            flit_type  <= BODY_FLIT;
        end else begin
            flit_valid <= send;
            if (state == IDLE && bus.req_valid) begin
                dest_x <= bus.req_dest_x;
                dest_y <= bus.req_dest_y;
                remain <= bus.req_len;
            end
            if (hdr_send) begin
                flit_out  <= make_header(X_S_ADDRESS, Y_S_ADDRESS, dest_x, dest_y);
                flit_type <= HDR_FLIT;
            end else if (data_fire) begin
                flit_out  <= bus.data_in;
                flit_type <= (remain == '0) ? TAIL_FLIT : BODY_FLIT;
                remain    <= remain - LEN_W'(1);
            end
        end
    end

    credit_counter #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .credit_in  (bus.credit_in),
        .has_credit (has_credit),
        .credit_err (bus.credit_err)
    );

    assign bus.req_ready  = req_ready;
    assign bus.data_ready = data_ready;
    assign bus.flit_valid = flit_valid;
    assign bus.flit_out   = flit_out;
    assign bus.flit_type  = flit_type;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: basic packet, credit starvation, coincident
// send/credit, credit overflow and mid-packet reset, checked against a flit queue.
module tb_ni_packetizer;
    import noc_pkg::*;

    localparam logic [1:0] LOC_X = 2'b00;
    localparam logic [1:0] LOC_Y = 2'b01;

    logic clk = 1'b0;
    logic rst;

    int checks    = 0;
    int failures  = 0;
    int flit_count;
    int word_idx;
    logic [7:0] words[$];
    logic [9:0] exp_q[$];

    ni_packetizer_if bus ();

    ni_packetizer #(
        .X_S_ADDRESS (LOC_X),
        .Y_S_ADDRESS (LOC_Y),
        .BUF_DEPTH   (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive credit, sample #1 after the edge, score any emitted flit
    task automatic applyStimulus(input logic credit);
        logic [9:0] e;
        bus.credit_in = credit;
        @(posedge clk);
        #1;
        if (bus.flit_valid) begin
            flit_count++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_flit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("flit_data", {24'd0, bus.flit_out}, {24'd0, e[7:0]});
                checkOutput("flit_type", {30'd0, bus.flit_type}, {30'd0, e[9:8]});
            end
            if (bus.flit_type != HDR_FLIT) word_idx++;
        end
        bus.data_valid = (word_idx < words.size());
        bus.data_in    = (word_idx < words.size()) ? words[word_idx] : 8'h00;
        bus.credit_in  = 1'b0;
    endtask

    // Queue the expected flits for the words already loaded, then hold a request for one cycle
    task automatic startRequest(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] len);
        flit_count = 0;
        word_idx   = 0;
        exp_q.delete();
        exp_q.push_back({HDR_FLIT, LOC_X, LOC_Y, dx, dy});
        for (int i = 0; i < words.size(); i++)
            exp_q.push_back({(i == words.size() - 1) ? TAIL_FLIT : BODY_FLIT, words[i]});
        bus.req_valid  = 1'b1;
        bus.req_dest_x = dx;
        bus.req_dest_y = dy;
        bus.req_len    = len;
        applyStimulus(1'b0);
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_dest_x = '0;
        bus.req_dest_y = '0;
        bus.req_len    = '0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.credit_in  = 1'b0;
        flit_count     = 0;
        word_idx       = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        checkOutput("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
        checkOutput("rst_flit_valid", {31'd0, bus.flit_valid}, 32'd0);
        checkOutput("rst_flit_out",   {24'd0, bus.flit_out},   32'h00);
        checkOutput("rst_flit_type",  {30'd0, bus.flit_type},  32'd0);
        checkOutput("rst_credit_err", {31'd0, bus.credit_err}, 32'd0);
        checkOutput("rst_count",      {29'd0, dut.u_credit.count}, 32'd4);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("[TB] basic packet to (2,3)");
        words = '{8'hAA, 8'hBB, 8'hCC};
        startRequest(2'd2, 2'd3, 4'd2);
        checkOutput("head_req_ready", {31'd0, bus.req_ready}, 32'd0);
        applyStimulus(1'b1);
        checkOutput("hdr_value", {24'd0, bus.flit_out}, 32'h1B);
        checkOutput("payload_data_ready", {31'd0, bus.data_ready}, 32'd1);
        repeat (3) applyStimulus(1'b1);
        checkOutput("basic_flit_count", flit_count, 32'd4);
        checkOutput("basic_exp_left", exp_q.size(), 32'd0);
        checkOutput("basic_idle", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("basic_count", {29'd0, dut.u_credit.count}, 32'd4);
        checkOutput("basic_err", {31'd0, bus.credit_err}, 32'd0);
        applyStimulus(1'b0);
        checkOutput("hold_valid", {31'd0, bus.flit_valid}, 32'd0);
        checkOutput("hold_out", {24'd0, bus.flit_out}, 32'hCC);
        checkOutput("hold_type", {30'd0, bus.flit_type}, {30'd0, TAIL_FLIT});

        $display("[TB] starvation, six words, no credit");
        words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        startRequest(2'd3, 2'd0, 4'd5);
        repeat (8) applyStimulus(1'b0);
        checkOutput("starve_flit_count", flit_count, 32'd4);
        checkOutput("starve_data_ready", {31'd0, bus.data_ready}, 32'd0);
        checkOutput("starve_flit_valid", {31'd0, bus.flit_valid}, 32'd0);
        checkOutput("starve_count", {29'd0, dut.u_credit.count}, 32'd0);
        applyStimulus(1'b1);
        checkOutput("release_no_flit_yet", {31'd0, bus.flit_valid}, 32'd0);
        checkOutput("release_data_ready", {31'd0, bus.data_ready}, 32'd1);
        applyStimulus(1'b0);
        checkOutput("release_flit", {31'd0, bus.flit_valid}, 32'd1);
        checkOutput("release_flit_count", flit_count, 32'd5);
        applyStimulus(1'b0);
        checkOutput("release_only_one", {31'd0, bus.flit_valid}, 32'd0);

        $display("[TB] send coincident with credit at count 1");
        applyStimulus(1'b1);
        checkOutput("coinc_pre_count", {29'd0, dut.u_credit.count}, 32'd1);
        applyStimulus(1'b1);
        checkOutput("coinc_flit", {31'd0, bus.flit_valid}, 32'd1);
        checkOutput("coinc_count", {29'd0, dut.u_credit.count}, 32'd1);
        checkOutput("coinc_next_ready", {31'd0, bus.data_ready}, 32'd1);
        applyStimulus(1'b0);
        checkOutput("coinc_tail", {31'd0, bus.flit_valid}, 32'd1);
        checkOutput("coinc_exp_left", exp_q.size(), 32'd0);
        checkOutput("coinc_idle", {31'd0, bus.req_ready}, 32'd1);
        repeat (4) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("refill_count", {29'd0, dut.u_credit.count}, 32'd4);
        checkOutput("refill_err", {31'd0, bus.credit_err}, 32'd0);

        $display("[TB] credit overflow");
        applyStimulus(1'b1);
        checkOutput("ovf_err", {31'd0, bus.credit_err}, 32'd1);
        checkOutput("ovf_count", {29'd0, dut.u_credit.count}, 32'd4);
        applyStimulus(1'b0);
        checkOutput("ovf_err_sticky", {31'd0, bus.credit_err}, 32'd1);
        words = '{8'h5A};
        startRequest(2'd1, 2'd1, 4'd0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("ovf_flit_count", flit_count, 32'd2);
        checkOutput("ovf_exp_left", exp_q.size(), 32'd0);
        checkOutput("ovf_err_kept", {31'd0, bus.credit_err}, 32'd1);
        checkOutput("ovf_count_after", {29'd0, dut.u_credit.count}, 32'd4);

        $display("[TB] reset mid-packet, self-addressed");
        words = '{8'h20, 8'h21, 8'h22, 8'h23};
        startRequest(2'd0, 2'd1, 4'd3);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("pre_rst_flit_count", flit_count, 32'd2);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_flit_valid", {31'd0, bus.flit_valid}, 32'd0);
        checkOutput("mid_rst_flit_out",   {24'd0, bus.flit_out},   32'h00);
        checkOutput("mid_rst_flit_type",  {30'd0, bus.flit_type},  32'd0);
        checkOutput("mid_rst_count",      {29'd0, dut.u_credit.count}, 32'd4);
        checkOutput("mid_rst_err",        {31'd0, bus.credit_err}, 32'd0);
        checkOutput("mid_rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        checkOutput("mid_rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
        exp_q.delete();
        words.delete();
        bus.data_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        words = '{8'h30, 8'h31};
        startRequest(2'd3, 2'd3, 4'd1);
        applyStimulus(1'b0);
        checkOutput("fresh_hdr_type", {30'd0, bus.flit_type}, {30'd0, HDR_FLIT});
        checkOutput("fresh_hdr_value", {24'd0, bus.flit_out}, 32'h1F);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("fresh_flit_count", flit_count, 32'd3);
        checkOutput("fresh_exp_left", exp_q.size(), 32'd0);
        checkOutput("fresh_count", {29'd0, dut.u_credit.count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
